// File: rtl/regfile_dump_reader.sv
// Debug-side register file dumper: walks every register over a spare read port
// and streams each word MSB byte first over a valid/ready byte interface.
module regfile_dump_reader #(
  parameter int unsigned NB_BITS  = 32,
  parameter int unsigned NB_DEPTH = 5,
  parameter int unsigned NB_BYTE  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic [NB_DEPTH-1:0] o_read_addr,
  input  logic [NB_BITS-1:0]  i_read_data,
  output logic [NB_BYTE-1:0]  o_byte,
  output logic                o_byte_valid,
  input  logic                i_byte_ready,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned NB_WBYTES = NB_BITS / NB_BYTE;
  localparam int unsigned NB_CNT    = (NB_WBYTES > 1) ? $clog2(NB_WBYTES) : 1;
  localparam logic [NB_CNT-1:0]   LAST_BYTE = NB_CNT'(NB_WBYTES - 1);
  localparam logic [NB_DEPTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NB_DEPTH-1:0] r_addr;
  logic [NB_DEPTH-1:0] w_addr_next;
  logic [NB_CNT-1:0]   r_byte_cnt;
  logic [NB_CNT-1:0]   w_byte_cnt_next;
  logic [NB_BITS-1:0]  r_shift;
  logic [NB_BITS-1:0]  w_shift_next;
  logic                w_xfer;

  assign w_xfer = (r_state == S_SEND) && i_byte_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_addr     <= w_addr_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_shift    <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_addr_next     = r_addr;
    w_byte_cnt_next = r_byte_cnt;
    w_shift_next    = r_shift;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_READ;
          w_addr_next  = '0;
        end
      end
      S_READ: begin
        w_shift_next    = i_read_data;
        w_byte_cnt_next = '0;
        w_state_next    = S_SEND;
      end
      S_SEND: begin
        if (w_xfer) begin
          if (r_byte_cnt != LAST_BYTE) begin
            w_shift_next    = r_shift << NB_BYTE;
            w_byte_cnt_next = r_byte_cnt + NB_CNT'(1);
          end else if (r_addr != LAST_ADDR) begin
            w_addr_next  = r_addr + NB_DEPTH'(1);
            w_state_next = S_READ;
          end else begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A start still held high chains straight into the next dump.
        w_addr_next  = '0;
        w_state_next = i_start ? S_READ : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_read_addr  = r_addr;
  assign o_byte_valid = (r_state == S_SEND);
  assign o_byte       = o_byte_valid ? r_shift[NB_BITS-1 -: NB_BYTE] : '0;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: 32-bit and 16-bit instances fed by
// a behavioural register file with known contents.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  byte_o;
  logic        valid;
  logic        busy;
  logic        done;

  logic        start16;
  logic        ready16;
  logic [4:0]  rd_addr16;
  logic [15:0] rd_data16;
  logic [7:0]  byte16;
  logic        valid16;
  logic        busy16;
  logic        done16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign rd_data   = 32'hA000_0000 | {27'h0, rd_addr};
  assign rd_data16 = 16'hBE00 | {11'h0, rd_addr16};

  regfile_dump_reader #(.NB_BITS(32), .NB_DEPTH(5), .NB_BYTE(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_read_addr(rd_addr),
    .i_read_data(rd_data), .o_byte(byte_o), .o_byte_valid(valid),
    .i_byte_ready(ready), .o_busy(busy), .o_done(done)
  );

  regfile_dump_reader #(.NB_BITS(16), .NB_DEPTH(5), .NB_BYTE(8)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start16), .o_read_addr(rd_addr16),
    .i_read_data(rd_data16), .o_byte(byte16), .o_byte_valid(valid16),
    .i_byte_ready(ready16), .o_busy(busy16), .o_done(done16)
  );

  function automatic logic [7:0] exp_byte32(input int b);
    logic [7:0] r;
    case (b % 4)
      0:       r = 8'hA0;
      3:       r = 8'(b / 4);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] exp_byte16(input int b);
    return (b % 2 == 0) ? 8'hBE : 8'(b / 2);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; start16 = 1'b0; ready = 1'b0; ready16 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b1; ready = 1'b1; start16 = 1'b1; ready16 = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (rd_addr !== 5'd0) begin miscompares++; $display("FAIL reset_addr: got %0d expected 0", rd_addr); end
    vectors++; if (byte_o !== 8'h00) begin miscompares++; $display("FAIL reset_byte: got %h expected 00", byte_o); end
    vectors++; if (busy16 !== 1'b0) begin miscompares++; $display("FAIL reset_busy16: got %b expected 0", busy16); end
    rst = 1'b1; start = 1'b0; start16 = 1'b0; ready = 1'b0; ready16 = 1'b0;
  endtask

  task automatic test_idle_ready();
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ready = 1'b1; start = 1'b0;
      vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid c=%0d: got %b expected 0", c, valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy c=%0d: got %b expected 0", c, busy); end
    end
  endtask

  task automatic test_full_dump();
    int nbytes = 0;
    apply_reset();
    for (int c = 0; c < 166; c++) begin
      @(negedge clk);
      start = (c == 0); ready = 1'b1;
      vectors++; if (busy !== (c >= 1 && c <= 161)) begin miscompares++; $display("FAIL dump_busy c=%0d: got %b", c, busy); end
      vectors++; if (done !== (c == 161)) begin miscompares++; $display("FAIL dump_done c=%0d: got %b", c, done); end
      vectors++; if (valid !== (c >= 2 && c <= 160 && ((c - 1) % 5) != 0)) begin miscompares++; $display("FAIL dump_valid c=%0d: got %b", c, valid); end
      if (c >= 1 && c <= 161) begin
        vectors++;
        if (rd_addr !== ((c == 161) ? 5'd31 : 5'((c - 1) / 5))) begin
          miscompares++; $display("FAIL dump_addr c=%0d: got %0d expected %0d", c, rd_addr, (c == 161) ? 31 : (c - 1) / 5);
        end
      end
      if (valid === 1'b1) begin
        if (nbytes < 128) begin
          vectors++; if (byte_o !== exp_byte32(nbytes)) begin miscompares++; $display("FAIL dump_byte %0d: got %h expected %h", nbytes, byte_o, exp_byte32(nbytes)); end
        end
        nbytes++;
      end
    end
    vectors++; if (nbytes != 128) begin miscompares++; $display("FAIL dump_count: got %0d expected 128", nbytes); end
    start = 1'b0;
  endtask

  task automatic test_ready_toggle();
    int nbytes = 0, ndone = 0;
    logic prev_valid = 1'b0, prev_ready = 1'b0, finished = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    int prev_pos = 0;
    apply_reset();
    for (int c = 0; c < 800 && !finished; c++) begin
      @(negedge clk);
      start = (c == 0); ready = (c % 2 == 0);
      if (prev_valid && !prev_ready) begin
        vectors++; if (valid !== 1'b1 || byte_o !== prev_byte) begin miscompares++; $display("FAIL toggle_hold c=%0d: got %b/%h expected 1/%h", c, valid, byte_o, prev_byte); end
      end else if (prev_valid && prev_ready && prev_pos != 3) begin
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL toggle_gap c=%0d: got %b expected 1", c, valid); end
      end
      prev_pos = nbytes % 4;
      if (valid === 1'b1 && ready) begin
        if (nbytes < 128) begin
          vectors++; if (byte_o !== exp_byte32(nbytes)) begin miscompares++; $display("FAIL toggle_byte %0d: got %h expected %h", nbytes, byte_o, exp_byte32(nbytes)); end
        end
        nbytes++;
      end
      if (done === 1'b1) begin ndone++; finished = 1'b1; end
      prev_valid = valid; prev_ready = ready; prev_byte = byte_o;
    end
    vectors++; if (!finished) begin miscompares++; $display("FAIL toggle_timeout: got no done expected done within 800 cycles"); end
    vectors++; if (nbytes != 128) begin miscompares++; $display("FAIL toggle_count: got %0d expected 128", nbytes); end
    vectors++; if (ndone != 1) begin miscompares++; $display("FAIL toggle_ndone: got %0d expected 1", ndone); end
    start = 1'b0;
  endtask

  task automatic test_start_ignored();
    int nbytes = 0, ndone = 0;
    apply_reset();
    for (int c = 0; c < 164; c++) begin
      @(negedge clk);
      start = (c == 0 || c == 10 || c == 80 || (c >= 150 && c <= 162)); ready = 1'b1;
      if (c <= 161) begin
        if (valid === 1'b1) nbytes++;
        if (done === 1'b1) ndone++;
      end
      if (c == 161) begin
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL start_done161: got %b expected 1", done); end
      end
      if (c == 162) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy: got %b expected 1", busy); end
        vectors++; if (rd_addr !== 5'd0) begin miscompares++; $display("FAIL restart_addr: got %0d expected 0", rd_addr); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL restart_read_valid: got %b expected 0", valid); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL restart_done: got %b expected 0", done); end
      end
      if (c == 163) begin
        vectors++; if (valid !== 1'b1 || byte_o !== 8'hA0) begin miscompares++; $display("FAIL restart_byte: got %b/%h expected 1/a0", valid, byte_o); end
      end
    end
    vectors++; if (nbytes != 128) begin miscompares++; $display("FAIL start_count: got %0d expected 128", nbytes); end
    vectors++; if (ndone != 1) begin miscompares++; $display("FAIL start_ndone: got %0d expected 1", ndone); end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    int nbytes = 0;
    apply_reset();
    @(negedge clk);
    start = 1'b1; ready = 1'b1;
    for (int c = 0; c < 400 && nbytes < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid === 1'b1 && ready) nbytes++;
    end
    vectors++; if (nbytes != 50) begin miscompares++; $display("FAIL mid_timeout: got %0d expected 50", nbytes); end
    @(negedge clk);
    rst = 1'b0; ready = 1'b0;
    @(negedge clk);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b expected 0", valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b expected 0", busy); end
    vectors++; if (rd_addr !== 5'd0) begin miscompares++; $display("FAIL mid_addr: got %0d expected 0", rd_addr); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_idle_valid: got %b expected 0", valid); end
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || rd_addr !== 5'd0 || valid !== 1'b0) begin miscompares++; $display("FAIL mid_restart_read: got busy=%b addr=%0d valid=%b expected 1/0/0", busy, rd_addr, valid); end
    @(negedge clk);
    vectors++; if (valid !== 1'b1 || byte_o !== 8'hA0) begin miscompares++; $display("FAIL mid_restart_byte: got %b/%h expected 1/a0", valid, byte_o); end
  endtask

  task automatic test_width16();
    int nbytes = 0;
    apply_reset();
    for (int c = 0; c < 101; c++) begin
      @(negedge clk);
      start16 = (c == 0); ready16 = 1'b1;
      vectors++; if (done16 !== (c == 97)) begin miscompares++; $display("FAIL w16_done c=%0d: got %b", c, done16); end
      vectors++; if (busy16 !== (c >= 1 && c <= 97)) begin miscompares++; $display("FAIL w16_busy c=%0d: got %b", c, busy16); end
      if (valid16 === 1'b1) begin
        if (nbytes < 64) begin
          vectors++; if (byte16 !== exp_byte16(nbytes)) begin miscompares++; $display("FAIL w16_byte %0d: got %h expected %h", nbytes, byte16, exp_byte16(nbytes)); end
        end
        nbytes++;
      end
    end
    vectors++; if (nbytes != 64) begin miscompares++; $display("FAIL w16_count: got %0d expected 64", nbytes); end
    start16 = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ready = 1'b0; start16 = 1'b0; ready16 = 1'b0;
    test_reset();
    test_idle_ready();
    test_full_dump();
    test_ready_toggle();
    test_start_ignored();
    test_reset_mid_dump();
    test_width16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
